// File: rtl/dual_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | dual_fetch_unit                                                        |
// | Dual-issue fetch stage driving a 2-port sync ROM and the F/D register. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module dual_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12,
  parameter logic [4:0]  HALT_OP  = 5'b11111
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               stall_i,
  input  logic               issue_one_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [IMEM_AW-1:0] imem_addr_top_o,
  output logic [IMEM_AW-1:0] imem_addr_bot_o,
  input  logic [31:0]        imem_data_top_i,
  input  logic [31:0]        imem_data_bot_i,
  output logic [31:0]        pc_out_top_o,
  output logic [31:0]        pc_out_bot_o,
  output logic [31:0]        instr_out_top_o,
  output logic [31:0]        instr_out_bot_o,
  output logic               f_we_o,
  output logic [31:0]        fetch_count_o
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [IMEM_AW-1:0] ADDR_ONE = IMEM_AW'(1);

  logic [1:0]  fsm_q, fsm_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic pair_valid;
  logic consume;
  logic top_halt;
  logic bot_halt;

  assign pair_valid = (fsm_q == S_RUN) & ~redirect_i;
  assign consume    = pair_valid & ~stall_i;
  assign top_halt   = (imem_data_top_i[31:27] == HALT_OP);
  assign bot_halt   = (imem_data_bot_i[31:27] == HALT_OP);

  always_comb begin
    inflight_pc_d = inflight_pc_q;
    fsm_d         = fsm_q;
    fetch_count_d = fetch_count_q;
    if (redirect_i) begin
      inflight_pc_d = redirect_pc_i;
      fsm_d         = S_RUN;
    end else begin
      case (fsm_q)
        S_BOOT: begin
          inflight_pc_d = RESET_PC;
          fsm_d         = S_RUN;
        end
        S_RUN: begin
          if (!stall_i) begin
            inflight_pc_d = issue_one_i ? (inflight_pc_q + 32'd1) : (inflight_pc_q + 32'd2);
            // A top HALT retires alone; a bot HALT only retires with the full pair.
            if (top_halt) begin
              fetch_count_d = fetch_count_q + 32'd1;
              fsm_d         = S_HALTED;
            end else if (issue_one_i) begin
              fetch_count_d = fetch_count_q + 32'd1;
            end else begin
              fetch_count_d = fetch_count_q + 32'd2;
              if (bot_halt) begin
                fsm_d = S_HALTED;
              end
            end
          end
        end
        S_HALTED: begin
          inflight_pc_d = inflight_pc_q;
        end
        default: begin
          inflight_pc_d = RESET_PC;
          fsm_d         = S_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q         <= S_BOOT;
      inflight_pc_q <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      fsm_q         <= fsm_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr_top_o = inflight_pc_d[IMEM_AW-1:0];
  assign imem_addr_bot_o = inflight_pc_d[IMEM_AW-1:0] + ADDR_ONE;

  assign pc_out_top_o    = inflight_pc_q;
  assign pc_out_bot_o    = inflight_pc_q + 32'd1;
  assign instr_out_top_o = pair_valid ? imem_data_top_i : 32'd0;
  assign instr_out_bot_o = (pair_valid & ~(consume & top_halt)) ? imem_data_bot_i : 32'd0;
  // Redirect is masked while in reset so the reset-time enable is just ~stall.
  assign f_we_o          = ~stall_i | (redirect_i & rst_ni);
  assign fetch_count_o   = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dual_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_dual_fetch_unit                                                     |
// | Scoreboard bench with a PC-level reference model of the fetch stage.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_dual_fetch_unit;

  localparam int          AW     = 12;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HALT_W = 32'hF800_0000;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          stall_i = 1'b0;
  logic          issue_one_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = 32'd0;
  logic [AW-1:0] imem_addr_top_o, imem_addr_bot_o;
  logic [31:0]   imem_data_top_i = 32'd0;
  logic [31:0]   imem_data_bot_i = 32'd0;
  logic [31:0]   pc_out_top_o, pc_out_bot_o, instr_out_top_o, instr_out_bot_o;
  logic          f_we_o;
  logic [31:0]   fetch_count_o;

  always #5 clk = ~clk;

  dual_fetch_unit #(.RESET_PC(RST_PC), .IMEM_AW(AW), .HALT_OP(5'b11111)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i), .issue_one_i(issue_one_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_addr_top_o(imem_addr_top_o), .imem_addr_bot_o(imem_addr_bot_o),
    .imem_data_top_i(imem_data_top_i), .imem_data_bot_i(imem_data_bot_i),
    .pc_out_top_o(pc_out_top_o), .pc_out_bot_o(pc_out_bot_o),
    .instr_out_top_o(instr_out_top_o), .instr_out_bot_o(instr_out_bot_o),
    .f_we_o(f_we_o), .fetch_count_o(fetch_count_o)
  );

  logic [31:0] rom [0:4095];
  always @(posedge clk) begin
    imem_data_top_i <= rom[imem_addr_top_o];
    imem_data_bot_i <= rom[imem_addr_bot_o];
  end

  typedef struct {
    logic [31:0]   pt, pb, it, ib, cnt;
    logic          we;
    logic [AW-1:0] at, ab;
    bit            chk_pc, chk_addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model: 0 = booting, 1 = running, 2 = halted.
  int          mst = 0;
  logic [31:0] mpc = RST_PC;
  logic [31:0] mcnt = 32'd0;

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    return rom[a[AW-1:0]];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t        e;
    logic [31:0] t, b, nxt;
    bit          v, th, bh;
    if (!rst_ni) begin
      mst = 0; mpc = RST_PC; mcnt = 32'd0;
    end
    t  = rom_at(mpc);
    b  = rom_at(mpc + 32'd1);
    th = (t[31:27] == 5'b11111);
    bh = (b[31:27] == 5'b11111);
    e.pt = mpc; e.pb = mpc + 32'd1; e.cnt = mcnt;
    e.it = 32'd0; e.ib = 32'd0;
    e.chk_pc = (mst != 2);
    e.chk_addr = 1'b0;
    e.at = '0; e.ab = '0;
    if (!rst_ni) begin
      e.we = ~stall_i;
      sb.push_back(e);
      return;
    end
    e.we = ~stall_i | redirect_i;
    v = (mst == 1) && !redirect_i;
    if (v) begin
      e.it = t;
      e.ib = (!stall_i && th) ? 32'd0 : b;
    end
    if (redirect_i) begin
      mpc = redirect_pc_i; mst = 1;
    end else if (mst == 0) begin
      mpc = RST_PC; mst = 1;
    end else if (mst == 1 && !stall_i) begin
      if (th) begin
        mcnt = mcnt + 32'd1; mst = 2;
      end else if (issue_one_i) begin
        mpc = mpc + 32'd1; mcnt = mcnt + 32'd1;
      end else begin
        mpc = mpc + 32'd2; mcnt = mcnt + 32'd2;
        if (bh) mst = 2;
      end
    end
    nxt = mpc + 32'd1;
    e.chk_addr = (mst != 2);
    e.at = mpc[AW-1:0];
    e.ab = nxt[AW-1:0];
    sb.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit st, input bit io, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    rst_ni = r; stall_i = st; issue_one_i = io; redirect_i = rd; redirect_pc_i = rpc;
    model_step();
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    stall_i = 1'b0; issue_one_i = 1'b0; redirect_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_instr_top", instr_out_top_o, 32'd0);
    chk("arst_instr_bot", instr_out_bot_o, 32'd0);
    chk("arst_count", fetch_count_o, 32'd0);
    chk("arst_pc_top", pc_out_top_o, RST_PC);
    chk("arst_f_we", {31'd0, f_we_o}, 32'd1);
    model_step();
  endtask

  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        me = sb.pop_front();
        if (me.chk_pc) begin
          chk("pc_top", pc_out_top_o, me.pt);
          chk("pc_bot", pc_out_bot_o, me.pb);
        end
        chk("instr_top", instr_out_top_o, me.it);
        chk("instr_bot", instr_out_bot_o, me.ib);
        chk("f_we", {31'd0, f_we_o}, {31'd0, me.we});
        chk("fetch_count", fetch_count_o, me.cnt);
        if (me.chk_addr) begin
          chk("addr_top", {20'd0, imem_addr_top_o}, {20'd0, me.at});
          chk("addr_bot", {20'd0, imem_addr_bot_o}, {20'd0, me.ab});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] w, rpc;
    bit          r, st, io, rd;
    for (int i = 0; i < 4096; i++) begin
      if (i < 'h40) begin
        rom[i] = 32'h100 + i;
      end else begin
        w = $urandom;
        if (w[31:27] == 5'b11111) w[31] = 1'b0;
        rom[i] = w;
      end
    end
    rom['h22]  = HALT_W;
    rom['h151] = HALT_W;
    rom['h2A0] = HALT_W;

    // Boot and straight-line fetch.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Stall three cycles at pair (4,5), then release.
    repeat (3) cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Split issue at (6,7), then normal advance.
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Redirect under stall to 0x20, then run into the HALT at 0x22.
    cycle(1, 1, 0, 1, 32'h20);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 32'h0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Asynchronous reset mid-run, then the boot sequence again.
    async_reset_check();
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom % 400) != 0;
      st = ($urandom % 4) == 0;
      io = ($urandom % 3) == 0;
      rd = ($urandom % 16) == 0 || (mst == 2 && ($urandom % 3) == 0);
      case ($urandom % 6)
        0:       rpc = $urandom;
        1:       rpc = 32'h20 + ($urandom % 4);
        2:       rpc = 32'h14F + ($urandom % 4);
        3:       rpc = ($urandom & 32'hFFFF_F000) | 32'hFFE | ($urandom & 32'h1);
        4:       rpc = 32'hFFFF_FFFF;
        default: rpc = 32'h29E + ($urandom % 4);
      endcase
      cycle(r, st, io, rd, rpc);
    end

    @(negedge clk);
    #6;
    chk("scoreboard_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
